// File: rtl/burst_pkg.sv
// Shared types and width helpers for the burst accumulator.
// Contents: acc_w/cnt_w width functions, default-width result_t record,
// acc_state_t FSM encoding.
package burst_pkg;

  localparam int unsigned DEF_WIDTH_A   = 8;
  localparam int unsigned DEF_WIDTH_B   = 8;
  localparam int unsigned DEF_MAX_BURST = 16;

  // Sum width: product width plus headroom for MAX_BURST additions.
  function automatic int unsigned acc_w(input int unsigned wa,
                                        input int unsigned wb,
                                        input int unsigned max_burst);
    return wa + wb + $clog2(max_burst);
  endfunction

  // Count width: must be able to hold MAX_BURST itself.
  function automatic int unsigned cnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int unsigned DEF_ACC_W = acc_w(DEF_WIDTH_A, DEF_WIDTH_B, DEF_MAX_BURST);
  localparam int unsigned DEF_CNT_W = cnt_w(DEF_MAX_BURST);

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] sum;
    logic        [DEF_CNT_W-1:0] count;
    logic                        trunc;
  } result_t;

  typedef enum logic {IDLE, ACCUM} acc_state_t;

endpackage

// File: rtl/burst_accum_if.sv
// Result stream of the burst accumulator (valid/ready).
// master: producer drives sum_data/sum_count/sum_trunc/sum_valid, samples sum_ready.
// slave : consumer samples the result fields, drives sum_ready.
interface burst_accum_if
  import burst_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic signed [ACC_W-1:0] sum_data;
  logic        [CNT_W-1:0] sum_count;
  logic                    sum_trunc;
  logic                    sum_valid;
  logic                    sum_ready;

  modport master (output sum_data, sum_count, sum_trunc, sum_valid,
                  input  sum_ready);
  modport slave  (input  sum_data, sum_count, sum_trunc, sum_valid,
                  output sum_ready);
endinterface

// File: rtl/res_fifo.sv
// Small synchronous FIFO for burst results.
// Ports: clk, rst_n (async low), push/wdata, pop, rdata (head, zero when
// empty), full, empty. A push while full is accepted only if a pop happens
// in the same cycle; otherwise it is ignored (caller flags the loss).
module res_fifo
  import burst_pkg::*;
#(
  parameter type         T     = result_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/burst_accum.sv
// Burst accumulator placed after a MULT_LAT-stage signed multiplier.
// Ports: clk, rst_n (async low); in_valid/in_last (presented with operands);
// prod (multiplier output); res (master: sum_data/sum_count/sum_trunc/
// sum_valid out, sum_ready in); err_drop (sticky result-loss flag);
// busy (burst open or marker still in flight).
module burst_accum
  import burst_pkg::*;
#(
  parameter int unsigned WIDTH_A    = 8,
  parameter int unsigned WIDTH_B    = 8,
  parameter int unsigned MULT_LAT   = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic signed [WIDTH_A+WIDTH_B-1:0] prod,
  burst_accum_if.master                     res,
  output logic                              err_drop,
  output logic                              busy
);
  localparam int unsigned ACC_W = acc_w(WIDTH_A, WIDTH_B, MAX_BURST);
  localparam int unsigned CNT_W = cnt_w(MAX_BURST);

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic        [CNT_W-1:0] count;
    logic                    trunc;
  } res_t;

  // Marker delay line: re-times valid/last to the product.
  logic [MULT_LAT-1:0] dly_vld;
  logic [MULT_LAT-1:0] dly_last;
  logic                p_vld;
  logic                p_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld  <= '0;
      dly_last <= '0;
    end else begin
      dly_vld  <= {dly_vld[MULT_LAT-2:0], in_valid};
      dly_last <= {dly_last[MULT_LAT-2:0], in_valid & in_last};
    end
  end

  assign p_vld  = dly_vld[MULT_LAT-1];
  assign p_last = dly_last[MULT_LAT-1];

  acc_state_t              state;
  acc_state_t              state_n;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_n;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] cnt_n;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_nxt;
  logic        [CNT_W-1:0] cnt_inc;
  logic                    push;
  res_t                    push_res;

  assign prod_ext = ACC_W'(prod);
  assign sum_nxt  = acc + prod_ext;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    push     = 1'b0;
    push_res = '0;
    case (state)
      IDLE: begin
        if (p_vld) begin
          if (p_last) begin
            push           = 1'b1;
            push_res.sum   = prod_ext;
            push_res.count = CNT_W'(1);
          end else begin
            acc_n   = prod_ext;
            cnt_n   = CNT_W'(1);
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (p_vld) begin
          // last takes precedence over the forced close when both coincide
          if (p_last || cnt_inc == CNT_W'(MAX_BURST)) begin
            push           = 1'b1;
            push_res.sum   = sum_nxt;
            push_res.count = cnt_inc;
            push_res.trunc = ~p_last;
            acc_n          = '0;
            cnt_n          = '0;
            state_n        = IDLE;
          end else begin
            acc_n = sum_nxt;
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  res_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign pop = ~fifo_empty & res.sum_ready;

  res_fifo #(.T(res_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_res),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res.sum_valid = ~fifo_empty;
  assign res.sum_data  = head.sum;
  assign res.sum_count = head.count;
  assign res.sum_trunc = head.trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_drop <= 1'b0;
    else if (push && fifo_full && !pop) err_drop <= 1'b1;
  end

  assign busy = (state == ACCUM) || (|dly_vld);
endmodule

// File: tb/tb_burst_accum.sv
// Directed self-checking bench for burst_accum. Includes a 4-stage signed
// multiplier model feeding prod, so operands are driven as (a,b) pairs.
module tb_burst_accum;
  import burst_pkg::*;

  localparam int unsigned WA  = 8;
  localparam int unsigned WB  = 8;
  localparam int unsigned LAT = 4;
  localparam int unsigned MB  = 16;
  localparam int unsigned FD  = 2;
  localparam int unsigned AW  = acc_w(WA, WB, MB);
  localparam int unsigned CW  = cnt_w(MB);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic signed [WA-1:0]    a = '0;
  logic signed [WB-1:0]    b = '0;
  logic signed [WA+WB-1:0] mpipe [LAT];
  logic signed [WA+WB-1:0] prod;
  logic                    err_drop;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;

  burst_accum_if #(.ACC_W(AW), .CNT_W(CW)) res_if ();

  burst_accum #(
    .WIDTH_A(WA), .WIDTH_B(WB), .MULT_LAT(LAT), .MAX_BURST(MB), .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .prod     (prod),
    .res      (res_if),
    .err_drop (err_drop),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // multiplier model: product of operands presented in cycle t visible in t+4
  always @(posedge clk) begin
    mpipe[0] <= a * b;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign prod = mpipe[LAT-1];

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int s, input int c, input int t);
    check({tag, ".valid"}, res_if.sum_valid, 1);
    check({tag, ".sum"},   res_if.sum_data,  s);
    check({tag, ".count"}, res_if.sum_count, c);
    check({tag, ".trunc"}, res_if.sum_trunc, t);
  endtask

  // drive one cycle of operands/markers, then advance to the next cycle
  task automatic present(input int va, input int vb, input logic v, input logic l);
    a        = WA'(va);
    b        = WB'(vb);
    in_valid = v;
    in_last  = l;
    ticks(1);
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_if.sum_ready = 1'b0;
    ticks(2);
    check("rst.valid", res_if.sum_valid, 0);
    check("rst.sum",   res_if.sum_data,  0);
    check("rst.count", res_if.sum_count, 0);
    check("rst.trunc", res_if.sum_trunc, 0);
    check("rst.err",   err_drop, 0);
    check("rst.busy",  busy, 0);
    rst_n = 1'b1;
    ticks(1);

    // single 4-sample burst: 6 - 20 - 7 + 16384 = 16363
    present(2, 3, 1, 0);
    check("t1.busy", busy, 1);
    present(-4, 5, 1, 0);
    present(7, -1, 1, 0);
    present(-128, -128, 1, 1);
    ticks(3);
    check("t1.early", res_if.sum_valid, 0);
    ticks(1);   // 9th cycle counting the first-pair cycle as cycle 1
    check_res("t1", 16363, 4, 0);
    ticks(1);
    check_res("t1.hold", 16363, 4, 0);
    res_if.sum_ready = 1'b1;
    ticks(1);
    check("t1.drain", res_if.sum_valid, 0);
    check("t1.idle", busy, 0);

    // back-to-back single-sample bursts, consumer always ready
    present(1, 1, 1, 1);
    present(-1, 1, 1, 1);
    present(5, 5, 1, 1);
    ticks(1);
    check("t2.early", res_if.sum_valid, 0);
    ticks(1);
    check_res("t2.r0", 1, 1, 0);
    ticks(1);
    check_res("t2.r1", -1, 1, 0);
    ticks(1);
    check_res("t2.r2", 25, 1, 0);
    ticks(1);
    check("t2.drain", res_if.sum_valid, 0);

    // 17 samples of -16256, last only on the 17th: forced close at 16
    for (int i = 0; i < 17; i++) present(-128, 127, 1, (i == 16));
    ticks(3);
    check_res("t3.r0", -260096, 16, 1);
    ticks(1);
    check_res("t3.r1", -16256, 1, 0);
    ticks(1);
    check("t3.drain", res_if.sum_valid, 0);

    // consumer stalled: third result (30) is lost
    res_if.sum_ready = 1'b0;
    present(1, 2, 1, 1);
    present(3, 4, 1, 1);
    present(5, 6, 1, 1);
    check("t4.err_pre", err_drop, 0);
    ticks(4);
    check_res("t4.r0", 2, 1, 0);
    check("t4.err", err_drop, 1);
    res_if.sum_ready = 1'b1;
    ticks(1);
    check_res("t4.r1", 12, 1, 0);
    ticks(1);
    check("t4.drain", res_if.sum_valid, 0);
    check("t4.sticky", err_drop, 1);

    // reset during the 3rd sample of a 5-sample burst
    present(1, 1, 1, 0);
    present(1, 1, 1, 0);
    a = 8'sd1; b = 8'sd1; in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5.rst.valid", res_if.sum_valid, 0);
    check("t5.rst.sum",   res_if.sum_data,  0);
    check("t5.rst.err",   err_drop, 0);
    check("t5.rst.busy",  busy, 0);
    ticks(1);
    in_valid = 1'b0;
    a = '0; b = '0;
    rst_n = 1'b1;
    present(1, 1, 0, 0);
    present(1, 1, 0, 0);
    ticks(6);
    check("t5.ghost", res_if.sum_valid, 0);
    check("t5.busy",  busy, 0);
    present(2, 2, 1, 1);
    ticks(4);
    check_res("t5.r0", 4, 1, 0);
    ticks(1);
    check("t5.drain", res_if.sum_valid, 0);

    // FIFO full, pop coincides with a push: push accepted, no drop
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    res_if.sum_ready = 1'b0;
    ticks(1);
    present(1, 3, 1, 1);
    present(2, 3, 1, 1);
    present(3, 3, 1, 1);
    ticks(3);
    check_res("t6.r0", 3, 1, 0);
    res_if.sum_ready = 1'b1;
    ticks(1);
    res_if.sum_ready = 1'b0;
    check_res("t6.r1", 6, 1, 0);
    check("t6.err", err_drop, 0);
    res_if.sum_ready = 1'b1;
    ticks(1);
    check_res("t6.r2", 9, 1, 0);
    ticks(1);
    check("t6.drain", res_if.sum_valid, 0);
    check("t6.err_end", err_drop, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
